// File: rtl/both_negedge_unit.sv
// Falling-edge probe: counts falling clk edges since reset release and reports
// release pulse, toggle, sticky wrap and registered reset status.
module both_negedge_unit #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   output logic [WIDTH-1:0] cnt,
   output logic             tog,
   output logic             rel_pulse,
   output logic             wrapped,
   output logic             in_reset
);

   logic rst_q;

   // rst is sampled only here, so a change in the same time step as the
   // falling edge is seen at the following falling edge.
   always_ff @(negedge clk) begin
      if (rst) begin
         cnt       <= '0;
         tog       <= 1'b0;
         rel_pulse <= 1'b0;
         wrapped   <= 1'b0;
         in_reset  <= 1'b1;
         rst_q     <= 1'b1;
      end else if (rst_q) begin
         // Release edge: flagged but not counted.
         cnt       <= '0;
         rel_pulse <= 1'b1;
         in_reset  <= 1'b0;
         rst_q     <= 1'b0;
      end else begin
         cnt       <= cnt + 1'b1;
         tog       <= ~tog;
         rel_pulse <= 1'b0;
         in_reset  <= 1'b0;
         if (cnt == '1) begin
            wrapped <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_both_negedge_unit.sv
// Scoreboard bench for both_negedge_unit: directed stimulus pushes expected
// output sets; a monitor pops and compares after every falling edge or probe.
module tb_both_negedge_unit;

   logic       clk;
   logic       rst;
   logic [7:0] cnt8;
   logic [3:0] cnt4;
   logic       tog8, rel8, wrap8, inr8;
   logic       tog4, rel4, wrap4, inr4;

   both_negedge_unit #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .cnt       (cnt8),
      .tog       (tog8),
      .rel_pulse (rel8),
      .wrapped   (wrap8),
      .in_reset  (inr8)
   );

   both_negedge_unit #(.WIDTH(4)) dut4 (
      .clk       (clk),
      .rst       (rst),
      .cnt       (cnt4),
      .tog       (tog4),
      .rel_pulse (rel4),
      .wrapped   (wrap4),
      .in_reset  (inr4)
   );

   typedef struct {
      logic [7:0] c8;
      logic [3:0] c4;
      logic       tog;
      logic       rel;
      logic       w8;
      logic       w4;
      logic       inr;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   event sample_ev;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s at %0t: got=%0h want=%0h", name, $time, got, want);
      end
   endtask

   function automatic void push(input int c, input bit t, input bit r,
                                input bit w8, input bit w4, input bit inr);
      exp_t e;
      e.c8  = c[7:0];
      e.c4  = c[3:0];
      e.tog = t;
      e.rel = r;
      e.w8  = w8;
      e.w4  = w4;
      e.inr = inr;
      exp_q.push_back(e);
   endfunction

   function automatic void push_reset();
      push(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
   endfunction

   // One 10 ns clock period: falling edge, then rising edge.
   task automatic tick();
      #5 clk = 1'b0;
      #5 clk = 1'b1;
   endtask

   // Monitor: one expected entry per falling edge or explicit probe.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk or sample_ev);
         #1;
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_sample at %0t: got=no_entry want=entry", $time);
         end else begin
            e = exp_q.pop_front();
            chk("cnt8",  32'(cnt8),  32'(e.c8));
            chk("cnt4",  32'(cnt4),  32'(e.c4));
            chk("tog8",  32'(tog8),  32'(e.tog));
            chk("tog4",  32'(tog4),  32'(e.tog));
            chk("rel8",  32'(rel8),  32'(e.rel));
            chk("rel4",  32'(rel4),  32'(e.rel));
            chk("wrap8", 32'(wrap8), 32'(e.w8));
            chk("wrap4", 32'(wrap4), 32'(e.w4));
            chk("inr8",  32'(inr8),  32'(e.inr));
            chk("inr4",  32'(inr4),  32'(e.inr));
         end
      end
   end

   initial begin
      int k;
      clk = 1'b1;
      rst = 1'b1;
      #100;

      // clk and rst fall in the same time step: the edge still sees rst=1.
      push_reset();
      clk = 1'b0;
      rst <= 1'b0;
      #5 clk = 1'b1;
      rst = 1'b1;

      repeat (3) begin
         push_reset();
         tick();
      end

      // Release mid-cycle; run past the 4-bit wrap (edge 17) and the
      // 8-bit wrap (edge 257), stopping with cnt=7.
      rst = 1'b0;
      for (k = 1; k <= 264; k++) begin
         push(k - 1, bit'((k - 1) % 2), k == 1, k >= 257, k >= 17, 1'b0);
         tick();
      end

      // Reset for a single edge while running, then a fresh release.
      rst = 1'b1;
      push_reset();
      tick();
      rst = 1'b0;
      for (k = 1; k <= 3; k++) begin
         push(k - 1, bit'((k - 1) % 2), k == 1, 1'b0, 1'b0, 1'b0);
         tick();
      end

      // rst pulse entirely between falling edges is never sampled.
      for (k = 4; k <= 6; k++) begin
         #1 rst = 1'b1;
         #2 rst = 1'b0;
         push(k - 1, bit'((k - 1) % 2), 1'b0, 1'b0, 1'b0, 1'b0);
         tick();
      end

      // Clock held high after its last rise: nothing may change.
      #20;
      push(5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      -> sample_ev;
      #10;

      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/both_negedge_unit.md
Name: both_negedge_unit

Overview:
- Small self-contained timing/observability block. All state updates on the falling edge of the single clock.
- Counts falling clock edges since reset release and flags the reset-release event, plus toggle and wrap status.
- Used as a bring-up probe for negative-edge clocking and for the case where clock and reset fall together.
- No data inputs. Every input other than clock and reset is out of scope.

Parameters:
- WIDTH, 8, width of the falling-edge counter (legal range 2..32).

Ports:
- clk  input  1  single clock; all registers update on its falling edge.
- rst  input  1  reset; synchronous, active-high, sampled on the falling edge of clk.
- cnt  output  WIDTH  number of falling clk edges since reset release, modulo 2^WIDTH.
- tog  output  1  toggles on every non-reset falling edge.
- rel_pulse  output  1  high for exactly one clk cycle (falling edge to falling edge) after reset deasserts.
- wrapped  output  1  sticky flag, set when cnt wraps from all-ones to zero.
- in_reset  output  1  registered copy of rst, as sampled at the last falling edge.

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high. Ports are named clk and rst. There is no asynchronous path; rst takes effect only at a falling edge of clk.
- Sampling rule: at each falling clk edge the block uses the rst value present immediately before that edge. An rst change in the same simulation time step as the clk edge takes effect at the next falling edge. Implement this with non-blocking assignments in a single negedge process.
- Internal register rst_q holds the rst value sampled at the previous falling edge. It resets to 1.
- When sampled rst=1: cnt=0, tog=0, rel_pulse=0, wrapped=0, in_reset=1, rst_q=1.
- When sampled rst=0 and rst_q=1 (first edge out of reset):
  - cnt=0; the release edge itself is not counted.
  - tog unchanged (0).
  - rel_pulse=1, in_reset=0, rst_q=0.
- When sampled rst=0 and rst_q=0:
  - cnt=cnt+1, modulo 2^WIDTH.
  - tog=~tog; rel_pulse=0; in_reset=0.
  - wrapped=1 if the old cnt was all-ones, otherwise wrapped holds its value.
- Latency:
  - rel_pulse asserts at the first falling edge with rst sampled 0, and clears at the next falling edge.
  - cnt reaches N at the (N+1)th falling edge after release.
- Reset mid-operation: any falling edge with rst sampled 1 returns every output to its reset value on that edge. The next release produces a fresh rel_pulse.
- Rising clk edges have no effect on any output.
- Power-up: outputs are undefined until the first falling edge with rst=1.
- Wrap: after release, cnt counts 0..2^WIDTH-1, then 0 again, with wrapped=1 from that edge until reset. tog keeps alternating across the wrap.
- Outputs come directly from registers; there are no combinational paths from inputs.

Test Plan:
- clk=1, rst=1 for 100 ns, then clk and rst both fall in the same time step, clk held 0 -> that edge samples rst=1. Outputs hold reset values: cnt=0, tog=0, rel_pulse=0, wrapped=0, in_reset=1.
- rst=1 for 3 falling edges, then rst=0 (changed mid-cycle), free-running 10 ns clk -> edge 1 after release: rel_pulse=1, cnt=0, in_reset=0. Edge 2: rel_pulse=0, cnt=1, tog=1. Edge 5: cnt=4, tog=0.
- WIDTH=4, 17 falling edges after release -> cnt=15 at edge 16, cnt=0 and wrapped=1 at edge 17. wrapped stays 1 until reset.
- Running with cnt=7, assert rst for one falling edge, then release -> that edge gives cnt=0, tog=0, wrapped=0, in_reset=1. The next edge gives rel_pulse=1. The edge after gives cnt=1.
- rst pulsed high between two falling edges and low again before the next falling edge -> no effect: cnt keeps incrementing, rel_pulse stays 0.
- Rising edges only (clk held high after a rise, rst=0) -> no output changes.
